// File: rtl/id_ex_operand_stage.sv
// ID->EX pipeline register: holds decoded operands/control, forwards from MEM/WB,
// selects immediate vs rs2, and inserts one bubble on a load-use hazard.
module id_ex_operand_stage #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [RA_W-1:0]   id_rs1_addr,
  input  logic [RA_W-1:0]   id_rs2_addr,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              id_use_imm,
  input  logic [CTRL_W-1:0] id_alu_control,
  input  logic [RA_W-1:0]   id_rd_addr,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [XLEN-1:0]   alu_inp1,
  output logic [XLEN-1:0]   alu_inp2,
  output logic [CTRL_W-1:0] alu_control,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [RA_W-1:0]   ex_rd_addr,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  input  logic [RA_W-1:0]   mem_rd_addr,
  input  logic              mem_reg_write,
  input  logic [XLEN-1:0]   mem_result,
  input  logic [RA_W-1:0]   wb_rd_addr,
  input  logic              wb_reg_write,
  input  logic [XLEN-1:0]   wb_result,
  output logic [CNT_W-1:0]  bubble_count
);

  typedef struct packed {
    logic [RA_W-1:0]   rs1_addr;
    logic [RA_W-1:0]   rs2_addr;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic              use_imm;
    logic [CTRL_W-1:0] alu_control;
    logic [RA_W-1:0]   rd_addr;
    logic              reg_write;
    logic              mem_read;
  } held_t;

  held_t             held_q, held_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  bubble_count_q, bubble_count_d;
  logic              hazard;
  logic [XLEN-1:0]   fwd_rs1, fwd_rs2;

  function automatic logic [XLEN-1:0] forward(
    input logic [RA_W-1:0] addr,
    input logic [XLEN-1:0] held_data,
    input logic            m_we,
    input logic [RA_W-1:0] m_rd,
    input logic [XLEN-1:0] m_res,
    input logic            w_we,
    input logic [RA_W-1:0] w_rd,
    input logic [XLEN-1:0] w_res
  );
    logic [XLEN-1:0] r;
    r = held_data;
    if (addr != '0 && m_we && m_rd == addr)      r = m_res;
    else if (addr != '0 && w_we && w_rd == addr) r = w_res;
    return r;
  endfunction

  // A held load whose rd feeds a source the incoming instruction actually reads.
  assign hazard = valid_q && held_q.mem_read && (held_q.rd_addr != '0) &&
                  ((held_q.rd_addr == id_rs1_addr) ||
                   ((held_q.rd_addr == id_rs2_addr) && !id_use_imm));

  assign id_ready = (!valid_q || ex_ready) && !hazard;

  always_comb begin
    held_d         = held_q;
    valid_d        = valid_q;
    bubble_count_d = bubble_count_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (id_valid && id_ready) begin
      held_d.rs1_addr    = id_rs1_addr;
      held_d.rs2_addr    = id_rs2_addr;
      held_d.rs1_data    = id_rs1_data;
      held_d.rs2_data    = id_rs2_data;
      held_d.imm         = id_imm;
      held_d.use_imm     = id_use_imm;
      held_d.alu_control = id_alu_control;
      held_d.rd_addr     = id_rd_addr;
      held_d.reg_write   = id_reg_write;
      held_d.mem_read    = id_mem_read;
      valid_d            = 1'b1;
    end else if (hazard && ex_ready) begin
      valid_d = 1'b0;
      if (bubble_count_q != '1) bubble_count_d = bubble_count_q + 1'b1;
    end else if (valid_q && ex_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q         <= '0;
      valid_q        <= 1'b0;
      bubble_count_q <= '0;
    end else begin
      held_q         <= held_d;
      valid_q        <= valid_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  always_comb begin
    fwd_rs1 = forward(held_q.rs1_addr, held_q.rs1_data, mem_reg_write, mem_rd_addr,
                      mem_result, wb_reg_write, wb_rd_addr, wb_result);
    fwd_rs2 = forward(held_q.rs2_addr, held_q.rs2_data, mem_reg_write, mem_rd_addr,
                      mem_result, wb_reg_write, wb_rd_addr, wb_result);
  end

  assign ex_valid      = valid_q;
  assign alu_inp1      = fwd_rs1;
  assign alu_inp2      = held_q.use_imm ? held_q.imm : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign alu_control   = held_q.alu_control;
  assign ex_rd_addr    = held_q.rd_addr;
  assign ex_reg_write  = held_q.reg_write && valid_q;
  assign ex_mem_read   = held_q.mem_read && valid_q;
  assign bubble_count  = bubble_count_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage; a second instance with CNT_W=2 shares
// the stimulus to observe bubble-counter saturation.
module tb_id_ex_operand_stage;
  logic        clk, rst_n;
  logic        id_valid, id_ready;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        id_use_imm, id_reg_write, id_mem_read;
  logic [3:0]  id_alu_control;
  logic        flush, ex_ready, ex_valid;
  logic [31:0] alu_inp1, alu_inp2, ex_store_data;
  logic [3:0]  alu_control;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write, ex_mem_read;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] mem_result, wb_result;
  logic [15:0] bubble_count;

  logic        s_id_ready, s_ex_valid, s_ex_reg_write, s_ex_mem_read;
  logic [31:0] s_alu_inp1, s_alu_inp2, s_ex_store_data;
  logic [3:0]  s_alu_control;
  logic [4:0]  s_ex_rd_addr;
  logic [1:0]  s_bubble_count;

  int checks = 0;
  int errors = 0;

  id_ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_alu_control(id_alu_control), .id_rd_addr(id_rd_addr),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .alu_inp1(alu_inp1), .alu_inp2(alu_inp2),
    .alu_control(alu_control), .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .bubble_count(bubble_count)
  );

  id_ex_operand_stage #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(s_id_ready),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_alu_control(id_alu_control), .id_rd_addr(id_rd_addr),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .ex_ready(ex_ready), .ex_valid(s_ex_valid), .alu_inp1(s_alu_inp1), .alu_inp2(s_alu_inp2),
    .alu_control(s_alu_control), .ex_store_data(s_ex_store_data), .ex_rd_addr(s_ex_rd_addr),
    .ex_reg_write(s_ex_reg_write), .ex_mem_read(s_ex_mem_read),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .bubble_count(s_bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [3:0] ctrl, input logic [4:0] rd,
                       input logic ld);
    id_valid = 1'b1; id_rs1_addr = rs1; id_rs2_addr = rs2; id_rs1_data = d1;
    id_rs2_data = d2; id_alu_control = ctrl; id_rd_addr = rd; id_reg_write = 1'b1;
    id_mem_read = ld; id_use_imm = 1'b0; id_imm = '0;
  endtask

  initial begin
    rst_n = 1'b0; id_valid = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_use_imm = 0; id_reg_write = 0;
    id_mem_read = 0; id_alu_control = 0; flush = 0; ex_ready = 1;
    mem_rd_addr = 0; wb_rd_addr = 0; mem_reg_write = 0; wb_reg_write = 0;
    mem_result = 0; wb_result = 0;
    #12;
    check("rst_ex_valid", 32'(ex_valid), 0);
    check("rst_alu_control", 32'(alu_control), 0);
    check("rst_alu_inp1", alu_inp1, 0);
    check("rst_alu_inp2", alu_inp2, 0);
    check("rst_bubbles", 32'(bubble_count), 0);
    check("rst_id_ready", 32'(id_ready), 1);
    @(negedge clk); rst_n = 1'b1;

    // add x3 = x1 + x2
    offer(5'd1, 5'd2, 32'd5, 32'd7, 4'b0010, 5'd3, 1'b0);
    step();
    check("cap_valid", 32'(ex_valid), 1);
    check("cap_inp1", alu_inp1, 5);
    check("cap_inp2", alu_inp2, 7);
    check("cap_ctrl", 32'(alu_control), 32'b0010);
    check("cap_rd", 32'(ex_rd_addr), 3);
    check("cap_regwr", 32'(ex_reg_write), 1);

    // immediate selects operand 2, store data keeps rs2
    offer(5'd1, 5'd2, 32'd5, 32'd9, 4'b0010, 5'd3, 1'b0);
    id_use_imm = 1'b1; id_imm = 32'h100;
    step();
    check("imm_inp2", alu_inp2, 32'h100);
    check("imm_store", ex_store_data, 9);

    // forwarding priority on rs1 = x4
    offer(5'd4, 5'd0, 32'h33, 32'h0, 4'b0110, 5'd8, 1'b0);
    step();
    id_valid = 1'b0;
    mem_rd_addr = 5'd4; mem_reg_write = 1'b1; mem_result = 32'h11;
    wb_rd_addr = 5'd4; wb_reg_write = 1'b1; wb_result = 32'h22;
    #1 check("fwd_mem_wins", alu_inp1, 32'h11);
    mem_reg_write = 1'b0;
    #1 check("fwd_wb", alu_inp1, 32'h22);
    wb_reg_write = 1'b0;
    #1 check("fwd_none", alu_inp1, 32'h33);
    offer(5'd0, 5'd0, 32'h44, 32'h0, 4'b0110, 5'd8, 1'b0);
    step();
    id_valid = 1'b0;
    mem_rd_addr = 5'd0; mem_reg_write = 1'b1; mem_result = 32'h11;
    wb_rd_addr = 5'd0; wb_reg_write = 1'b1; wb_result = 32'h22;
    #1 check("fwd_x0", alu_inp1, 32'h44);
    mem_reg_write = 1'b0; wb_reg_write = 1'b0;

    // load-use: load x5, then add reading x5
    offer(5'd1, 5'd0, 32'h0, 32'h0, 4'b0010, 5'd5, 1'b1);
    step();
    check("lu_load_held", 32'(ex_mem_read), 1);
    offer(5'd5, 5'd2, 32'h0, 32'h7, 4'b0010, 5'd6, 1'b0);
    #1 check("lu_id_ready", 32'(id_ready), 0);
    step();
    check("lu_bubble_valid", 32'(ex_valid), 0);
    check("lu_bubble_regwr", 32'(ex_reg_write), 0);
    check("lu_count", 32'(bubble_count), 1);
    step();
    check("lu_add_valid", 32'(ex_valid), 1);
    check("lu_add_rd", 32'(ex_rd_addr), 6);
    check("lu_add_memrd", 32'(ex_mem_read), 0);
    id_valid = 1'b0;

    // asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1 check("async_valid", 32'(ex_valid), 0);
    check("async_count", 32'(bubble_count), 0);
    @(negedge clk); rst_n = 1'b1;

    // backpressure then flush
    offer(5'd1, 5'd2, 32'hAA, 32'h0, 4'b0100, 5'd7, 1'b0);
    step();
    ex_ready = 1'b0;
    offer(5'd1, 5'd2, 32'hBB, 32'h0, 4'b0101, 5'd9, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_id_ready", 32'(id_ready), 0);
      step();
      check("bp_valid", 32'(ex_valid), 1);
      check("bp_inp1", alu_inp1, 32'hAA);
      check("bp_ctrl", 32'(alu_control), 32'b0100);
    end
    flush = 1'b1;
    step();
    flush = 1'b0; id_valid = 1'b0;
    check("flush_valid", 32'(ex_valid), 0);
    step();
    check("flush_dropped", 32'(ex_valid), 0);
    ex_ready = 1'b1;

    // five load-use bubbles: 16-bit counter reaches 5, 2-bit counter pins at 3
    for (int i = 0; i < 5; i++) begin
      offer(5'd1, 5'd0, 32'h0, 32'h0, 4'b0010, 5'd5, 1'b1);
      step();
      offer(5'd2, 5'd5, 32'h0, 32'h0, 4'b0010, 5'd6, 1'b0);
      step();
      check("sat_small", 32'(s_bubble_count), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
      step();
    end
    id_valid = 1'b0;
    check("sat_wide", 32'(bubble_count), 5);
    check("sat_small_final", 32'(s_bubble_count), 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
